// File: rtl/ldpc_enc_sequencer.sv
// ldpc_enc_sequencer: control FSM for the QC-LDPC encoder datapath.
//   Accepts a frame request with a one-hot Z select, walks the info-column
//   groups (ROM address, accumulator clear/enable), runs the parity-resolve
//   steps, then holds out_valid until the downstream takes the codeword.
// Ports:
//   CLK, rst            clock, synchronous active-low reset
//   start_valid/ready   frame request handshake (ready only in IDLE)
//   req_z               one-hot lifting-size select, sampled at accept
//   in_valid/ready      info beat handshake (ready only in LOAD)
//   rom_addr            proto-matrix word address = z_idx*COLS + col_idx
//   acc_clr, acc_en     accumulator load / capture strobes
//   col_idx             current column group
//   par_en, par_step    parity-resolve step strobe and index
//   z_idx               latched binary Z index
//   out_valid/ready     codeword-complete handshake
//   err_zsel            one-cycle pulse after a non-one-hot request
module ldpc_enc_sequencer #(
    parameter int NUM_Z           = 3,
    parameter int NUM_INFO_BLKS   = 20,
    parameter int NUM_PARITY_BLKS = 4,
    parameter int P_LVL           = 1,
    parameter int ROM_ADDR_W      = 9,
    localparam int COLS = NUM_INFO_BLKS / P_LVL,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int PW   = (NUM_PARITY_BLKS > 1) ? $clog2(NUM_PARITY_BLKS) : 1,
    localparam int ZW   = (NUM_Z > 1) ? $clog2(NUM_Z) : 1
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [NUM_Z-1:0]      req_z,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  acc_clr,
    output logic                  acc_en,
    output logic [CW-1:0]         col_idx,
    output logic                  par_en,
    output logic [PW-1:0]         par_step,
    output logic [ZW-1:0]         z_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_zsel
);

    if (NUM_INFO_BLKS % P_LVL != 0) begin : g_chk_div
        $fatal(1, "NUM_INFO_BLKS must be a multiple of P_LVL");
    end
    if (NUM_Z * COLS > 2 ** ROM_ADDR_W) begin : g_chk_rom
        $fatal(1, "ROM_ADDR_W too small for NUM_Z*COLS words");
    end

    typedef enum logic [1:0] {IDLE, LOAD, PARITY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [PW-1:0]   step_q, step_d;
    logic [ZW-1:0]   z_q, z_d;
    logic            err_q, err_d;
    logic [ZW-1:0]   z_bin;
    logic            beat;

    always_comb begin
        z_bin = '0;
        for (int i = 0; i < NUM_Z; i++)
            if (req_z[i]) z_bin = ZW'(i);
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            step_q  <= '0;
            z_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            step_q  <= step_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        step_d      = step_q;
        z_d         = z_q;
        err_d       = 1'b0;
        start_ready = (state_q == IDLE);
        in_ready    = (state_q == LOAD);
        par_en      = (state_q == PARITY);
        out_valid   = (state_q == DONE);
        beat        = in_ready && in_valid;
        acc_en      = beat;
        acc_clr     = beat && (col_q == '0);
        case (state_q)
            IDLE: begin
                // A malformed request is still consumed so the source is not stuck.
                if (start_valid) begin
                    if ($onehot(req_z)) begin
                        state_d = LOAD;
                        col_d   = '0;
                        z_d     = z_bin;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    if (col_q == CW'(COLS - 1)) begin
                        col_d   = '0;
                        step_d  = '0;
                        state_d = PARITY;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (step_q == PW'(NUM_PARITY_BLKS - 1)) begin
                    step_d  = '0;
                    state_d = DONE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rom_addr = (state_q == IDLE) ? '0
                    : ROM_ADDR_W'(z_q) * ROM_ADDR_W'(COLS) + ROM_ADDR_W'(col_q);
    assign col_idx  = col_q;
    assign par_step = step_q;
    assign z_idx    = z_q;
    assign err_zsel = err_q;

endmodule

// File: tb/tb_ldpc_enc_sequencer.sv
// tb_ldpc_enc_sequencer: self-checking bench for ldpc_enc_sequencer.
//   Frame-level reference: beat k of a frame with Z index z must present
//   rom_addr z*COLS+k, then NUM_PARITY_BLKS parity steps, then out_valid
//   COLS+NUM_PARITY_BLKS+1+stalls cycles after accept.
module tb_ldpc_enc_sequencer;

    localparam int COLS = 20;
    localparam int NPB  = 4;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       start_valid = 1'b0;
    logic [2:0] req_z = 3'b000;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       start_ready, in_ready, acc_clr, acc_en, par_en, out_valid, err_zsel;
    logic [8:0] rom_addr;
    logic [4:0] col_idx;
    logic [1:0] par_step, z_idx;

    logic       b_start_ready, b_in_ready, b_acc_clr, b_acc_en, b_par_en, b_out_valid, b_err_zsel;
    logic [8:0] b_rom_addr;
    logic [3:0] b_col_idx;
    logic [1:0] b_par_step, b_z_idx;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    ldpc_enc_sequencer dut (
        .CLK(CLK), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .req_z(req_z), .in_valid(in_valid), .in_ready(in_ready), .rom_addr(rom_addr),
        .acc_clr(acc_clr), .acc_en(acc_en), .col_idx(col_idx), .par_en(par_en),
        .par_step(par_step), .z_idx(z_idx), .out_valid(out_valid), .out_ready(out_ready),
        .err_zsel(err_zsel)
    );

    ldpc_enc_sequencer #(.P_LVL(2)) dut_p2 (
        .CLK(CLK), .rst(rst), .start_valid(start_valid), .start_ready(b_start_ready),
        .req_z(req_z), .in_valid(in_valid), .in_ready(b_in_ready), .rom_addr(b_rom_addr),
        .acc_clr(b_acc_clr), .acc_en(b_acc_en), .col_idx(b_col_idx), .par_en(b_par_en),
        .par_step(b_par_step), .z_idx(b_z_idx), .out_valid(b_out_valid), .out_ready(out_ready),
        .err_zsel(b_err_zsel)
    );

    typedef struct {
        logic       sv;
        logic [2:0] rz;
        logic       err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " start_ready"}, 32'(start_ready), 1);
        chk({tag, " in_ready"}, 32'(in_ready), 0);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " par_en"}, 32'(par_en), 0);
        chk({tag, " acc_en"}, 32'(acc_en), 0);
        chk({tag, " rom_addr"}, 32'(rom_addr), 0);
    endtask

    // One complete frame on the P_LVL=1 instance.
    task automatic frame(input int z, input int stall_pct, input bit t2, input int hold);
        int k, st, stalls, acc_t;
        start_valid = 1'b1;
        req_z = 3'(1 << z);
        @(negedge CLK);
        chk("accept start_ready", 32'(start_ready), 1);
        acc_t = cyc;
        next_cycle();
        start_valid = 1'($urandom);
        req_z = 3'($urandom);
        k = 0; st = 0; stalls = 0;
        for (int c = 0; c < 4 * COLS + 50 && k < COLS; c++) begin
            if (t2) in_valid = !((k == 5 || k == 12) && st < 3);
            else    in_valid = ($urandom_range(99) >= stall_pct);
            @(negedge CLK);
            chk("load in_ready", 32'(in_ready), 1);
            chk("load rom_addr", 32'(rom_addr), z * COLS + k);
            chk("load col_idx", 32'(col_idx), k);
            chk("load z_idx", 32'(z_idx), z);
            chk("load acc_en", 32'(acc_en), 32'(in_valid));
            chk("load acc_clr", 32'(acc_clr), 32'(in_valid && k == 0));
            chk("load par_en", 32'(par_en), 0);
            chk("load start_ready", 32'(start_ready), 0);
            if (in_valid) begin k++; st = 0; end
            else begin st++; stalls++; end
            next_cycle();
        end
        chk("beats consumed", k, COLS);
        for (int s = 0; s < NPB; s++) begin
            in_valid = 1'($urandom);
            @(negedge CLK);
            chk("parity par_en", 32'(par_en), 1);
            chk("parity par_step", 32'(par_step), s);
            chk("parity in_ready", 32'(in_ready), 0);
            chk("parity acc_en", 32'(acc_en), 0);
            chk("parity out_valid", 32'(out_valid), 0);
            next_cycle();
        end
        start_valid = 1'b1;
        req_z = 3'b001;
        for (int h = 0; h <= hold; h++) begin
            out_ready = (h == hold);
            @(negedge CLK);
            if (h == 0) chk("latency", cyc - acc_t, COLS + NPB + 1 + stalls);
            chk("done out_valid", 32'(out_valid), 1);
            chk("done start_ready", 32'(start_ready), 0);
            chk("done par_en", 32'(par_en), 0);
            next_cycle();
        end
        start_valid = 1'b0;
        out_ready = 1'($urandom);
        @(negedge CLK);
        chk_idle("post");
        chk("post err_zsel", 32'(err_zsel), 0);
        next_cycle();
    endtask

    initial begin
        int t0;
        tbl[0] = '{1'b1, 3'b011, 1'b1};
        tbl[1] = '{1'b1, 3'b000, 1'b1};
        tbl[2] = '{1'b0, 3'b001, 1'b0};
        tbl[3] = '{1'b1, 3'b110, 1'b1};
        tbl[4] = '{1'b0, 3'b000, 1'b0};
        tbl[5] = '{1'b1, 3'b111, 1'b1};
        tbl[6] = '{1'b1, 3'b101, 1'b1};
        tbl[7] = '{1'b0, 3'b100, 1'b0};

        // Reset state
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge CLK);
        chk_idle("reset");
        chk("reset col_idx", 32'(col_idx), 0);
        chk("reset par_step", 32'(par_step), 0);
        chk("reset z_idx", 32'(z_idx), 0);
        chk("reset err_zsel", 32'(err_zsel), 0);
        chk("reset acc_clr", 32'(acc_clr), 0);
        next_cycle();

        // T1 / T2
        frame(2, 0, 1'b0, 0);
        frame(0, 0, 1'b1, 0);

        // T3: table of IDLE-only requests; err_zsel lags its request by one cycle
        for (int i = 0; i < 8; i++) begin
            start_valid = tbl[i].sv;
            req_z = tbl[i].rz;
            in_valid = 1'($urandom);
            @(negedge CLK);
            chk_idle("tbl");
            chk("tbl err_zsel", 32'(err_zsel), (i == 0) ? 0 : 32'(tbl[i-1].err));
            next_cycle();
        end
        start_valid = 1'b0;
        @(negedge CLK);
        chk("tbl err_zsel tail", 32'(err_zsel), 32'(tbl[7].err));
        next_cycle();

        // T4: reset in the middle of a Z index 1 frame
        start_valid = 1'b1;
        req_z = 3'b010;
        next_cycle();
        start_valid = 1'b0;
        in_valid = 1'b1;
        repeat (7) next_cycle();
        @(negedge CLK);
        chk("t4 col_idx before rst", 32'(col_idx), 7);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge CLK);
        chk_idle("t4");
        chk("t4 col_idx", 32'(col_idx), 0);
        chk("t4 z_idx", 32'(z_idx), 0);
        next_cycle();
        frame(1, 0, 1'b0, 0);

        // T5: out_ready held low for 10 cycles in DONE
        frame(1, 20, 1'b0, 10);

        // Randomized frames
        for (int n = 0; n < 25; n++)
            frame($urandom_range(2), $urandom_range(50), 1'b0, $urandom_range(4));

        // T6: P_LVL=2 instance
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        start_valid = 1'b1;
        req_z = 3'b100;
        @(negedge CLK);
        chk("t6 start_ready", 32'(b_start_ready), 1);
        t0 = cyc;
        next_cycle();
        start_valid = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk("t6 in_ready", 32'(b_in_ready), 1);
            chk("t6 rom_addr", 32'(b_rom_addr), 20 + k);
            chk("t6 col_idx", 32'(b_col_idx), k);
            chk("t6 acc_clr", 32'(b_acc_clr), 32'(k == 0));
            chk("t6 z_idx", 32'(b_z_idx), 2);
            next_cycle();
        end
        for (int s = 0; s < NPB; s++) begin
            @(negedge CLK);
            chk("t6 par_en", 32'(b_par_en), 1);
            chk("t6 par_step", 32'(b_par_step), s);
            next_cycle();
        end
        @(negedge CLK);
        chk("t6 out_valid", 32'(b_out_valid), 1);
        chk("t6 latency", cyc - t0, 15);
        chk("t6 err_zsel", 32'(b_err_zsel), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
